perf_monitor: RTL and testbench
===============================

// Module: perf_monitor
// PURPOSE
//  Performance-counter stage downstream of the pipelined datapath. Consumes per-cycle event
//  strobes from the hazard unit and writeback stage and counts stalls, arithmetic and memory
//  instructions. On finish it freezes all counts and computes integer CPI (cycles/retired)
//  with a sequential restoring divider. Drives the read-only registers R28..R31.
// PARAMETERS
//  CNT_W  19  width of every counter, the divider and the R28..R31 outputs (>=4)
// PORTS
//  clkFPGA               in   1      single system clock, rising edge
//  rst                   in   1      synchronous, active-high reset
//  finish                in   1      program-end strobe from datapath (level or pulse)
//  stall_evt             in   1      pipeline stalled this cycle (hazard unit)
//  retire_evt            in   1      one instruction retired in WB this cycle
//  arith_evt             in   1      retiring instr is arithmetic (ignored unless retire_evt)
//  mem_evt               in   1      retiring instr is load/store (ignored unless retire_evt)
//  R28_stall_count       out  CNT_W  stall cycles
//  R29_aritmetric_count  out  CNT_W  arithmetic instructions retired
//  R30_memory_count      out  CNT_W  memory instructions retired
//  R31_cicles_per_inst   out  CNT_W  integer CPI; 0 until cpi_valid
//  cpi_valid             out  1      high in DONE state
// BEHAVIOUR
//  - Reset (rst high at an edge, any state): all counters, divider regs, R28..R31 and
//    cpi_valid = 0; state <= COUNT. rst has priority over every other input.
//  - FSM: COUNT -> DIVIDE on an edge sampling finish=1 in COUNT.
//    DIVIDE -> DONE after exactly CNT_W DIVIDE cycles.
//    DONE holds until rst. finish is ignored in DIVIDE and DONE.
//  - COUNT: at each edge, cyc_cnt += 1. stall_cnt += stall_evt. ret_cnt += retire_evt.
//    arith_cnt += retire_evt&arith_evt. mem_cnt += retire_evt&mem_evt.
//    arith_evt and mem_evt may both be set; each counter then increments independently.
//    Events sampled on the same edge as finish are counted, and that cycle is counted too.
//  - All counters saturate at 2^CNT_W-1; they never wrap.
//  - R28..R30 mirror their counters combinationally from the registers and update the
//    cycle after the event. They are frozen from DIVIDE onward.
//  - Divider: radix-2 restoring. Dividend = cyc_cnt, divisor = ret_cnt.
//    Remainder is CNT_W+1 bits; one quotient bit per DIVIDE cycle, MSB first.
//  - DONE entered CNT_W+1 edges after the finish-sampling edge. R31 = floor(cyc_cnt/ret_cnt)
//    from that edge, and cpi_valid = 1 on the same edge. Remainder is discarded.
//  - ret_cnt == 0: the divider is bypassed in effect. R31 = 2^CNT_W-1 in DONE, with the
//    same latency.
//  - rst mid-DIVIDE: abort; state COUNT, R31 = 0, cpi_valid = 0 on the next edge.
//  - No handshake: the datapath may sample R28..R31 at any time. R31 is meaningful only
//    while cpi_valid = 1.
// TESTING
//  1. rst, then 10 COUNT cycles with retire_evt on 5 of them, finish on the 10th edge ->
//     cyc=10, ret=5. Next edge: DIVIDE. After 20 edges: cpi_valid=1, R31=2.
//  2. 4 stall cycles, 3 arith retires, 2 mem retires, one retire with arith&mem set ->
//     R28=4, R29=4, R30=3.
//  3. arith_evt/mem_evt pulsed with retire_evt=0 -> R29, R30 unchanged.
//  4. finish with no retires -> R31 = 0x7FFFF, cpi_valid=1 after 20 edges.
//  5. CNT_W=4: 20 stall cycles -> R28 saturates at 15. 20 cycles with 1 retire -> R31=15.
//  6. rst on 5th DIVIDE cycle -> next edge: cpi_valid=0, R31=0, all counts 0, state COUNT.
//     Re-run scenario 1 -> R31=2.

Source files
------------

// File: rtl/perf_monitor_if.sv
// Event strobes from the datapath into the performance monitor, and the read-only
// counter registers R28..R31 back out to the datapath.
interface perf_monitor_if #(
  parameter int unsigned CNT_W = 19
);

  logic             finish;
  logic             stall_evt;
  logic             retire_evt;
  logic             arith_evt;
  logic             mem_evt;
  logic [CNT_W-1:0] R28_stall_count;
  logic [CNT_W-1:0] R29_aritmetric_count;
  logic [CNT_W-1:0] R30_memory_count;
  logic [CNT_W-1:0] R31_cicles_per_inst;
  logic             cpi_valid;

  // Datapath side: raises events, reads the counter registers.
  modport master (
    output finish,
    output stall_evt,
    output retire_evt,
    output arith_evt,
    output mem_evt,
    input  R28_stall_count,
    input  R29_aritmetric_count,
    input  R30_memory_count,
    input  R31_cicles_per_inst,
    input  cpi_valid
  );

  // Monitor side.
  modport slave (
    input  finish,
    input  stall_evt,
    input  retire_evt,
    input  arith_evt,
    input  mem_evt,
    output R28_stall_count,
    output R29_aritmetric_count,
    output R30_memory_count,
    output R31_cicles_per_inst,
    output cpi_valid
  );

endinterface

// File: rtl/perf_monitor.sv
// Performance counters for the pipelined datapath. Counts cycles, stalls, retired,
// arithmetic and memory instructions until finish, then freezes the counts and
// computes integer CPI (cycles / retired) with a radix-2 restoring divider.
module perf_monitor #(
  parameter int unsigned CNT_W = 19
) (
  input logic           clkFPGA,
  input logic           rst,
  perf_monitor_if.slave bus
);

  localparam int unsigned StepW = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StCount, StDivide, StDone} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] arith_q, arith_d;
  logic [CNT_W-1:0] mem_q, mem_d;

  logic [CNT_W-1:0] dvd_q, dvd_d;
  logic [CNT_W-1:0] quo_q, quo_d;
  logic [CNT_W:0]   rem_q, rem_d;
  logic [StepW-1:0] step_q, step_d;
  logic [CNT_W-1:0] r31_q, r31_d;

  logic [CNT_W:0]   rem_shift;
  logic [CNT_W:0]   rem_diff;
  logic             q_bit;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CntMax)) ? v + CNT_W'(1) : v;
  endfunction

  // Next counter values; only meaningful while counting, frozen otherwise.
  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    ret_d   = ret_q;
    arith_d = arith_q;
    mem_d   = mem_q;
    if (state_q == StCount) begin
      cyc_d   = sat_inc(cyc_q, 1'b1);
      stall_d = sat_inc(stall_q, bus.stall_evt);
      ret_d   = sat_inc(ret_q, bus.retire_evt);
      arith_d = sat_inc(arith_q, bus.retire_evt & bus.arith_evt);
      mem_d   = sat_inc(mem_q, bus.retire_evt & bus.mem_evt);
    end
  end

  // One restoring-division step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    rem_shift = {rem_q[CNT_W-1:0], dvd_q[CNT_W-1]};
    rem_diff  = rem_shift - {1'b0, ret_q};
    q_bit     = (rem_shift >= {1'b0, ret_q});
  end

  // FSM next state and divider datapath control.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    step_d  = step_q;
    r31_d   = r31_q;
    unique case (state_q)
      StCount: begin
        if (bus.finish) begin
          // Load the dividend with the count including this final cycle.
          state_d = StDivide;
          dvd_d   = cyc_d;
          quo_d   = '0;
          rem_d   = '0;
          step_d  = '0;
        end
      end
      StDivide: begin
        if (step_q == StepW'(CNT_W)) begin
          // All quotient bits produced; this edge commits the result.
          r31_d   = (ret_q == '0) ? CntMax : quo_q;
          state_d = StDone;
        end else begin
          rem_d  = q_bit ? rem_diff : rem_shift;
          quo_d  = {quo_q[CNT_W-2:0], q_bit};
          dvd_d  = {dvd_q[CNT_W-2:0], 1'b0};
          step_d = step_q + StepW'(1);
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StCount;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      state_q <= StCount;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter and divider registers.
  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
      ret_q   <= '0;
      arith_q <= '0;
      mem_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      step_q  <= '0;
      r31_q   <= '0;
    end else begin
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
      ret_q   <= ret_d;
      arith_q <= arith_d;
      mem_q   <= mem_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      r31_q   <= r31_d;
    end
  end

  assign bus.R28_stall_count      = stall_q;
  assign bus.R29_aritmetric_count = arith_q;
  assign bus.R30_memory_count     = mem_q;
  assign bus.R31_cicles_per_inst  = r31_q;
  assign bus.cpi_valid            = (state_q == StDone);

  // Once counting stops, the counts must not move until reset.
  assert property (@(posedge clkFPGA) disable iff (rst)
                   (state_q != StCount) |=> ($stable(cyc_q) && $stable(stall_q)));

  // Retired never exceeds cycles, so a valid CPI is never zero.
  assert property (@(posedge clkFPGA) disable iff (rst)
                   bus.cpi_valid |-> (bus.R31_cicles_per_inst != '0));

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: a 19-bit instance for the main scenarios and a
// 4-bit instance for saturation. Stimulus pushes expected register snapshots; monitors
// pop them on a probe strobe or on the rising edge of cpi_valid.
module tb_perf_monitor;

  logic clk = 1'b0;
  logic rst19 = 1'b1;
  logic rst4 = 1'b1;

  always #5 clk = ~clk;

  perf_monitor_if #(.CNT_W(19)) bus19 ();
  perf_monitor_if #(.CNT_W(4))  bus4 ();

  perf_monitor #(.CNT_W(19)) dut19 (.clkFPGA(clk), .rst(rst19), .bus(bus19));
  perf_monitor #(.CNT_W(4))  dut4  (.clkFPGA(clk), .rst(rst4),  .bus(bus4));

  typedef struct {
    string       name;
    int unsigned r28;
    int unsigned r29;
    int unsigned r30;
    int unsigned r31;
    bit          v;
    int unsigned lat;
  } exp_t;

  exp_t snap_q19[$];
  exp_t done_q19[$];
  exp_t snap_q4[$];
  exp_t done_q4[$];

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned edge_n = 0;
  int unsigned fin19 = 0;
  int unsigned fin4 = 0;
  bit snap19 = 1'b0;
  bit snap4 = 1'b0;
  bit v19_prev = 1'b0;
  bit v4_prev = 1'b0;

  always @(posedge clk) edge_n++;

  function automatic exp_t mk(string n, int unsigned a, int unsigned b, int unsigned c,
                              int unsigned d, bit v, int unsigned lat);
    exp_t e;
    e.name = n; e.r28 = a; e.r29 = b; e.r30 = c; e.r31 = d; e.v = v; e.lat = lat;
    return e;
  endfunction

  task automatic check(string name, int unsigned act, int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic compare(exp_t e, int unsigned r28, int unsigned r29, int unsigned r30,
                         int unsigned r31, bit v);
    check({e.name, ".R28"}, r28, e.r28);
    check({e.name, ".R29"}, r29, e.r29);
    check({e.name, ".R30"}, r30, e.r30);
    check({e.name, ".R31"}, r31, e.r31);
    check({e.name, ".cpi_valid"}, int'(v), int'(e.v));
  endtask

  // Monitor for the 19-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (snap19) begin
      if (snap_q19.size() == 0) check("snap19_queue_empty", 0, 1);
      else begin
        e = snap_q19.pop_front();
        compare(e, bus19.R28_stall_count, bus19.R29_aritmetric_count,
                bus19.R30_memory_count, bus19.R31_cicles_per_inst, bus19.cpi_valid);
      end
    end
    if (bus19.cpi_valid && !v19_prev) begin
      if (done_q19.size() == 0) check("unexpected_cpi_valid19", 1, 0);
      else begin
        e = done_q19.pop_front();
        compare(e, bus19.R28_stall_count, bus19.R29_aritmetric_count,
                bus19.R30_memory_count, bus19.R31_cicles_per_inst, bus19.cpi_valid);
        check({e.name, ".latency"}, edge_n - fin19, e.lat);
      end
    end
    v19_prev = bus19.cpi_valid;
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (snap4) begin
      if (snap_q4.size() == 0) check("snap4_queue_empty", 0, 1);
      else begin
        e = snap_q4.pop_front();
        compare(e, bus4.R28_stall_count, bus4.R29_aritmetric_count,
                bus4.R30_memory_count, bus4.R31_cicles_per_inst, bus4.cpi_valid);
      end
    end
    if (bus4.cpi_valid && !v4_prev) begin
      if (done_q4.size() == 0) check("unexpected_cpi_valid4", 1, 0);
      else begin
        e = done_q4.pop_front();
        compare(e, bus4.R28_stall_count, bus4.R29_aritmetric_count,
                bus4.R30_memory_count, bus4.R31_cicles_per_inst, bus4.cpi_valid);
        check({e.name, ".latency"}, edge_n - fin4, e.lat);
      end
    end
    v4_prev = bus4.cpi_valid;
  end

  task automatic drive19(bit st, bit re, bit ar, bit me, bit fi);
    bus19.stall_evt = st; bus19.retire_evt = re; bus19.arith_evt = ar;
    bus19.mem_evt = me; bus19.finish = fi;
    @(posedge clk); #1;
  endtask

  task automatic drive4(bit st, bit re, bit ar, bit me, bit fi);
    bus4.stall_evt = st; bus4.retire_evt = re; bus4.arith_evt = ar;
    bus4.mem_evt = me; bus4.finish = fi;
    @(posedge clk); #1;
  endtask

  task automatic probe19(exp_t e);
    snap_q19.push_back(e);
    snap19 = 1'b1;
    @(negedge clk); #1;
    snap19 = 1'b0;
  endtask

  task automatic probe4(exp_t e);
    snap_q4.push_back(e);
    snap4 = 1'b1;
    @(negedge clk); #1;
    snap4 = 1'b0;
  endtask

  task automatic reset19(string n);
    rst19 = 1'b1;
    drive19(0, 0, 0, 0, 0);
    drive19(0, 0, 0, 0, 0);
    probe19(mk(n, 0, 0, 0, 0, 0, 0));
    rst19 = 1'b0;
  endtask

  task automatic reset4(string n);
    rst4 = 1'b1;
    drive4(0, 0, 0, 0, 0);
    drive4(0, 0, 0, 0, 0);
    probe4(mk(n, 0, 0, 0, 0, 0, 0));
    rst4 = 1'b0;
  endtask

  // Bounded wait for the pending DONE expectation to be consumed.
  task automatic wait_done19(string n);
    for (int i = 0; i < 40; i++) begin
      if (done_q19.size() == 0) break;
      @(posedge clk); #1;
    end
    if (done_q19.size() != 0) begin
      check({n, ".timeout"}, 0, 1);
      done_q19.delete();
    end
  endtask

  task automatic wait_done4(string n);
    for (int i = 0; i < 20; i++) begin
      if (done_q4.size() == 0) break;
      @(posedge clk); #1;
    end
    if (done_q4.size() != 0) begin
      check({n, ".timeout"}, 0, 1);
      done_q4.delete();
    end
  endtask

  // 10 cycles, 5 retires, finish on the 10th edge: 10/5 = 2.
  task automatic run_s1(string n);
    reset19({n, "_reset"});
    for (int i = 1; i <= 10; i++) drive19(0, (i % 2) == 1, 0, 0, i == 10);
    fin19 = edge_n;
    bus19.finish = 1'b0;
    done_q19.push_back(mk({n, "_done"}, 0, 0, 0, 2, 1, 20));
    probe19(mk({n, "_dividing"}, 0, 0, 0, 0, 0, 0));
    wait_done19(n);
  endtask

  initial begin
    drive4(0, 0, 0, 0, 0);

    run_s1("s1");

    // Mixed events, then arith/mem without retire, then finish held high as a level.
    reset19("s2_reset");
    for (int i = 0; i < 4; i++) drive19(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive19(0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) drive19(0, 1, 0, 1, 0);
    drive19(0, 1, 1, 1, 0);
    probe19(mk("s2_counts", 4, 4, 3, 0, 0, 0));
    for (int i = 0; i < 3; i++) drive19(0, 0, 1, 1, 0);
    probe19(mk("s3_no_retire", 4, 4, 3, 0, 0, 0));
    drive19(0, 0, 0, 0, 1);
    fin19 = edge_n;
    // cycles 14, retired 6 -> 2; events during divide must not count
    done_q19.push_back(mk("s2_done", 4, 4, 3, 2, 1, 20));
    bus19.stall_evt = 1'b1; bus19.retire_evt = 1'b1; bus19.arith_evt = 1'b1;
    wait_done19("s2");
    drive19(1, 1, 1, 1, 1);
    drive19(1, 1, 1, 1, 1);
    probe19(mk("s2_done_hold", 4, 4, 3, 2, 1, 0));

    // No retires: CPI reads as all-ones.
    reset19("s4_reset");
    for (int i = 0; i < 7; i++) drive19(0, 0, 0, 0, 0);
    drive19(0, 0, 0, 0, 1);
    fin19 = edge_n;
    bus19.finish = 1'b0;
    done_q19.push_back(mk("s4_done", 0, 0, 0, 32'h7FFFF, 1, 20));
    wait_done19("s4");

    // Reset during the 5th divide cycle aborts, then a clean rerun.
    reset19("s6_reset");
    for (int i = 0; i < 3; i++) drive19(1, 1, 1, 0, 0);
    drive19(0, 0, 0, 0, 1);
    fin19 = edge_n;
    drive19(1, 1, 1, 1, 0);
    drive19(1, 1, 1, 1, 0);
    probe19(mk("s6_frozen", 3, 3, 0, 0, 0, 0));
    drive19(0, 0, 0, 0, 0);
    drive19(0, 0, 0, 0, 0);
    rst19 = 1'b1;
    drive19(0, 0, 0, 0, 0);
    probe19(mk("s6_abort", 0, 0, 0, 0, 0, 0));
    run_s1("s6_rerun");

    // 4-bit instance: stall counter and cycle counter saturate at 15; 15/1 = 15.
    reset4("s5_reset");
    for (int i = 1; i <= 20; i++) begin
      drive4(1, i == 1, 0, 0, i == 20);
      if (i == 19) probe4(mk("s5_sat_stall", 15, 0, 0, 0, 0, 0));
    end
    fin4 = edge_n;
    bus4.finish = 1'b0;
    done_q4.push_back(mk("s5_done", 15, 0, 0, 15, 1, 5));
    wait_done4("s5");

    // 4-bit instance: 7 cycles, 2 arith retires -> 7/2 = 3.
    reset4("s5b_reset");
    for (int i = 1; i <= 7; i++) drive4(0, (i == 2) || (i == 5), 1, 0, i == 7);
    fin4 = edge_n;
    bus4.finish = 1'b0;
    done_q4.push_back(mk("s5b_done", 0, 2, 0, 3, 1, 5));
    wait_done4("s5b");

    drive19(0, 0, 0, 0, 0);
    check("snap19_leftover", snap_q19.size(), 0);
    check("snap4_leftover", snap_q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
